button_event: RTL
=================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 50000000, high samples needed for a long press (>=2).
REQ-002 SHALL have parameter GAP_CYCLES, default 12500000, low samples closing a double-click window (>=2).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10000000, high samples between auto-repeat pulses once long (>=2).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port btn_level  input  1  debounced button level from the upstream debounce stage, 1 = pressed.
REQ-007 SHALL have port press_pulse  output  1  one-cycle pulse on each 0->1 of btn_level.
REQ-008 SHALL have port release_pulse  output  1  one-cycle pulse on each 1->0 of btn_level.
REQ-009 SHALL have port short_press  output  1  one-cycle pulse, single short press confirmed.
REQ-010 SHALL have port long_press  output  1  one-cycle pulse, hold reached LONG_CYCLES.
REQ-011 SHALL have port repeat_pulse  output  1  one-cycle pulse, periodic while long-held.
REQ-012 SHALL have port double_click  output  1  one-cycle pulse, second press inside the gap window.
REQ-013 SHALL have port held  output  1  level, 1 while FSM is in a pressed state.

Function
REQ-014 SHALL sample btn_level every clk; edge detect against registered previous sample prev (reset value 0).
REQ-015 SHALL register all outputs: each event appears in the cycle after the clk edge sampling the causing value (latency 1).
REQ-016 SHALL implement FSM states IDLE, PRESS1, LONG, GAP, PRESS2 with one shared counter sized clog2(max(parameters))+1, cleared on every state change.
REQ-017 IDLE: high sample -> PRESS1, press_pulse.
REQ-018 PRESS1: counts high samples including entry sample; low sample before count reaches LONG_CYCLES -> GAP, release_pulse; LONG_CYCLES-th high sample -> LONG, long_press.
REQ-019 LONG: every REPEAT_CYCLES further high samples -> repeat_pulse, counter restarts; low sample -> IDLE, release_pulse, no short_press.
REQ-020 GAP: counts low samples including entry sample; high sample after fewer than GAP_CYCLES low samples -> PRESS2, press_pulse and double_click in same cycle; GAP_CYCLES-th low sample -> IDLE, short_press.
REQ-021 PRESS2: no long/repeat detection; low sample -> IDLE, release_pulse, no short_press.
REQ-022 held SHALL be 1 in PRESS1, LONG, PRESS2, else 0.
REQ-023 Boundaries: release on exactly LONG_CYCLES-th sample impossible (sample is high -> long); exactly LONG_CYCLES-1 high then low -> short path; exactly GAP_CYCLES low -> short, next press is a new single press.
REQ-024 short_press, long_press, double_click SHALL be mutually exclusive per press sequence; at most one event class per sequence.
REQ-025 Counter SHALL never wrap; it is always cleared before exceeding its parameter.

Reset
REQ-026 rst high at a clk edge SHALL force state IDLE, counter 0, prev 0, all outputs 0 in the next cycle, overriding any event.
REQ-027 Reset mid-sequence SHALL discard the sequence without emitting any event.
REQ-028 btn_level high on first sample after reset SHALL be treated as a new press (press_pulse).

Verification (LONG_CYCLES=8, GAP_CYCLES=4, REPEAT_CYCLES=3)
REQ-029 high 3, low 10 -> press_pulse 1 cycle after 1st high; release_pulse after 1st low; short_press after 4th low; no other events.
REQ-030 high 7 then low 5 -> short_press; high 8 then low -> long_press after 8th high, no short_press.
REQ-031 high 14 -> long_press after 8th high, repeat_pulse after 11th and 14th high; held=1 throughout.
REQ-032 high 2, low 3, high 2, low 6 -> double_click with second press_pulse; no short_press.
REQ-033 high 2, low 4, high 2, low 6 -> short_press after 4th low; second press yields its own short_press; no double_click.
REQ-034 rst pulsed during LONG with btn_level high -> all outputs 0 next cycle, no release/short; press_pulse on first sample after rst falls.

Source files
------------

// File: rtl/button_event.sv
// Button event classifier.
// Turns a debounced button level into single-cycle event pulses: raw
// press/release edges, short press, long press, auto-repeat while long-held
// and double click. A single five-state FSM with one shared counter measures
// hold time and release gap. Every output is registered, so each event shows
// up in the cycle after the clock edge that sampled its cause.
module button_event #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int GAP_CYCLES    = 12500000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_click,
  output logic held
);

  localparam int MAX_AB  = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] LONG_C   = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] GAP_C    = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    LONG   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          prev;

  // Counter value including the sample being taken this cycle.
  always_comb begin
    cnt_inc = cnt + ONE_C;
  end

  // Edge detect, FSM and registered event outputs. On every state change the
  // counter restarts; states that count their entry sample start it at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      prev          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      double_click  <= 1'b0;
      held          <= 1'b0;
    end else begin
      prev          <= btn_level;
      press_pulse   <= btn_level & ~prev;
      release_pulse <= ~btn_level & prev;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      double_click  <= 1'b0;
      held          <= 1'b0;

      case (state)
        IDLE: begin
          if (btn_level) begin
            state <= PRESS1;
            cnt   <= ONE_C;
            held  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end

        PRESS1: begin
          if (!btn_level) begin
            // Released before reaching the long threshold: wait for a
            // possible second click.
            state <= GAP;
            cnt   <= ONE_C;
          end else if (cnt_inc == LONG_C) begin
            state      <= LONG;
            cnt        <= '0;
            long_press <= 1'b1;
            held       <= 1'b1;
          end else begin
            cnt  <= cnt_inc;
            held <= 1'b1;
          end
        end

        LONG: begin
          if (!btn_level) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_inc == REPEAT_C) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
            held         <= 1'b1;
          end else begin
            cnt  <= cnt_inc;
            held <= 1'b1;
          end
        end

        GAP: begin
          if (btn_level) begin
            // Second press arrived inside the window.
            state        <= PRESS2;
            cnt          <= '0;
            double_click <= 1'b1;
            held         <= 1'b1;
          end else if (cnt_inc == GAP_C) begin
            state       <= IDLE;
            cnt         <= '0;
            short_press <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        PRESS2: begin
          // The second press of a double click is never timed.
          cnt <= '0;
          if (!btn_level) begin
            state <= IDLE;
          end else begin
            held <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
